sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller command port between periodic refresh, video fetch and Zorro bus
// accesses. Commands are registered and held until the controller accepts them.
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 780,
    parameter int ZOR_MAX_WAIT   = 4
) (
    input  logic        z_sample_clk,
    input  logic        znRST,
    input  logic        vid_req,
    input  logic [22:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_data,
    output logic        vid_data_valid,
    input  logic        zor_req,
    input  logic        zor_write,
    input  logic [22:0] zor_addr,
    input  logic [15:0] zor_wdata,
    input  logic [1:0]  zor_mask,
    output logic        zor_ack,
    output logic [15:0] zor_rdata,
    output logic        ram_cmd_valid,
    output logic        ram_cmd_write,
    output logic        ram_cmd_refresh,
    output logic [22:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic [1:0]  ram_mask,
    input  logic        cmd_ready,
    input  logic        data_out_ready,
    input  logic [15:0] ram_rdata,
    output logic        ref_overrun
);

    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int WW = (ZOR_MAX_WAIT > 0) ? $clog2(ZOR_MAX_WAIT + 1) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
    localparam logic [WW-1:0] WAIT_MAX     = WW'(ZOR_MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE     = WW'(1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;

    localparam logic [1:0] SRC_REF = 2'd0;
    localparam logic [1:0] SRC_VID = 2'd1;
    localparam logic [1:0] SRC_ZOR = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] zwait_q, zwait_d;
    logic          ref_pending_q, ref_pending_d;
    logic          ref_overrun_q, ref_overrun_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_write_q, cmd_write_d;
    logic          cmd_refresh_q, cmd_refresh_d;
    logic [22:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    mask_q, mask_d;
    logic          vid_ack_q, vid_ack_d;
    logic [15:0]   vid_data_q, vid_data_d;
    logic          vid_data_valid_q, vid_data_valid_d;
    logic          zor_ack_q, zor_ack_d;
    logic [15:0]   zor_rdata_q, zor_rdata_d;
    logic          expire, accept, ref_done;

    always_comb begin
        state_d          = state_q;
        src_d            = src_q;
        zwait_d          = zwait_q;
        cmd_valid_d      = cmd_valid_q;
        cmd_write_d      = cmd_write_q;
        cmd_refresh_d    = cmd_refresh_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        mask_d           = mask_q;
        vid_data_d       = vid_data_q;
        zor_rdata_d      = zor_rdata_q;
        vid_ack_d        = 1'b0;
        vid_data_valid_d = 1'b0;
        zor_ack_d        = 1'b0;

        // A refresh accepted on the expiry cycle is immediately replaced by the new request.
        expire        = (timer_q == '0);
        timer_d       = expire ? TIMER_RELOAD : timer_q - TIMER_ONE;
        accept        = (state_q == ISSUE) && cmd_valid_q && cmd_ready;
        ref_done      = accept && (src_q == SRC_REF);
        ref_pending_d = expire || (ref_pending_q && !ref_done);
        ref_overrun_d = ref_overrun_q || (expire && ref_pending_q && !ref_done);

        case (state_q)
            IDLE: begin
                if (!zor_req) zwait_d = '0;
                if (ref_pending_q) begin
                    src_d         = SRC_REF;
                    cmd_valid_d   = 1'b1;
                    cmd_write_d   = 1'b0;
                    cmd_refresh_d = 1'b1;
                    addr_d        = '0;
                    wdata_d       = '0;
                    mask_d        = 2'b00;
                    state_d       = ISSUE;
                end else if (zor_req && (!vid_req || zwait_q >= WAIT_MAX)) begin
                    src_d         = SRC_ZOR;
                    zwait_d       = '0;
                    cmd_valid_d   = 1'b1;
                    cmd_write_d   = zor_write;
                    cmd_refresh_d = 1'b0;
                    addr_d        = zor_addr;
                    wdata_d       = zor_wdata;
                    mask_d        = zor_mask;
                    state_d       = ISSUE;
                end else if (vid_req) begin
                    // Count video grants that a waiting Zorro request has had to sit through.
                    if (zor_req && zwait_q < WAIT_MAX) zwait_d = zwait_q + WAIT_ONE;
                    src_d         = SRC_VID;
                    cmd_valid_d   = 1'b1;
                    cmd_write_d   = 1'b0;
                    cmd_refresh_d = 1'b0;
                    addr_d        = vid_addr;
                    wdata_d       = '0;
                    mask_d        = 2'b11;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    cmd_valid_d = 1'b0;
                    if (src_q == SRC_REF) begin
                        state_d = IDLE;
                    end else if (src_q == SRC_ZOR && cmd_write_q) begin
                        zor_ack_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        vid_ack_d = (src_q == SRC_VID);
                        state_d   = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_out_ready) begin
                    if (src_q == SRC_VID) begin
                        vid_data_d       = ram_rdata;
                        vid_data_valid_d = 1'b1;
                    end else begin
                        zor_rdata_d = ram_rdata;
                        zor_ack_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge z_sample_clk or negedge znRST) begin
        if (!znRST) begin
            state_q          <= IDLE;
            src_q            <= SRC_REF;
            timer_q          <= TIMER_RELOAD;
            zwait_q          <= '0;
            ref_pending_q    <= 1'b0;
            ref_overrun_q    <= 1'b0;
            cmd_valid_q      <= 1'b0;
            cmd_write_q      <= 1'b0;
            cmd_refresh_q    <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            mask_q           <= '0;
            vid_ack_q        <= 1'b0;
            vid_data_q       <= '0;
            vid_data_valid_q <= 1'b0;
            zor_ack_q        <= 1'b0;
            zor_rdata_q      <= '0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            timer_q          <= timer_d;
            zwait_q          <= zwait_d;
            ref_pending_q    <= ref_pending_d;
            ref_overrun_q    <= ref_overrun_d;
            cmd_valid_q      <= cmd_valid_d;
            cmd_write_q      <= cmd_write_d;
            cmd_refresh_q    <= cmd_refresh_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            mask_q           <= mask_d;
            vid_ack_q        <= vid_ack_d;
            vid_data_q       <= vid_data_d;
            vid_data_valid_q <= vid_data_valid_d;
            zor_ack_q        <= zor_ack_d;
            zor_rdata_q      <= zor_rdata_d;
        end
    end

    assign ram_cmd_valid   = cmd_valid_q;
    assign ram_cmd_write   = cmd_write_q;
    assign ram_cmd_refresh = cmd_refresh_q;
    assign ram_addr        = addr_q;
    assign ram_wdata       = wdata_q;
    assign ram_mask        = mask_q;
    assign vid_ack         = vid_ack_q;
    assign vid_data        = vid_data_q;
    assign vid_data_valid  = vid_data_valid_q;
    assign zor_ack         = zor_ack_q;
    assign zor_rdata       = zor_rdata_q;
    assign ref_overrun     = ref_overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requester stimulus, a small SDRAM controller
// responder, and a negedge monitor that pops expected commands and acks as they appear.
module tb_sdram_arbiter;

    typedef struct {
        logic        write;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
        int          len;
    } cmd_t;

    typedef struct {
        logic        rd;
        logic [15:0] data;
    } zack_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [22:0] vid_addr = '0;
    logic        vid_ack;
    logic [15:0] vid_data;
    logic        vid_data_valid;
    logic        zor_req = 1'b0;
    logic        zor_write = 1'b0;
    logic [22:0] zor_addr = '0;
    logic [15:0] zor_wdata = '0;
    logic [1:0]  zor_mask = '0;
    logic        zor_ack;
    logic [15:0] zor_rdata;
    logic        ram_cmd_valid, ram_cmd_write, ram_cmd_refresh;
    logic [22:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [1:0]  ram_mask;
    logic        cmd_ready, data_out_ready;
    logic [15:0] ram_rdata;
    logic        ref_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_t        cmd_q[$];
    int          vack_q[$];
    logic [15:0] vdata_q[$];
    zack_t       zack_q[$];

    int rdy_delay  = 0;
    int data_delay = 2;
    bit block      = 1'b0;
    bit stray      = 1'b0;
    bit chk_period = 1'b0;
    int ref_cnt    = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.REFRESH_CYCLES(16), .ZOR_MAX_WAIT(4)) dut (
        .z_sample_clk(clk), .znRST(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_data(vid_data), .vid_data_valid(vid_data_valid),
        .zor_req(zor_req), .zor_write(zor_write), .zor_addr(zor_addr),
        .zor_wdata(zor_wdata), .zor_mask(zor_mask), .zor_ack(zor_ack), .zor_rdata(zor_rdata),
        .ram_cmd_valid(ram_cmd_valid), .ram_cmd_write(ram_cmd_write),
        .ram_cmd_refresh(ram_cmd_refresh), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_mask(ram_mask), .cmd_ready(cmd_ready), .data_out_ready(data_out_ready),
        .ram_rdata(ram_rdata), .ref_overrun(ref_overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Read data returned by the model controller is a fixed function of the word address.
    function automatic logic [15:0] rd_model(input logic [22:0] a);
        return a[15:0] ^ 16'h48FF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_vid(input logic [22:0] a, input int len);
        cmd_q.push_back('{1'b0, a, 16'h0000, 2'b11, len});
        vack_q.push_back(1);
        vdata_q.push_back(rd_model(a));
    endtask

    task automatic push_zor(input logic wr, input logic [22:0] a, input logic [15:0] d,
                            input logic [1:0] m);
        cmd_q.push_back('{wr, a, d, m, 1});
        zack_q.push_back('{!wr, rd_model(a)});
    endtask

    task automatic drain(input int bound);
        int t = 0;
        while ((cmd_q.size() + vack_q.size() + vdata_q.size() + zack_q.size()) != 0
               || vid_req || zor_req) begin
            tick();
            if (vid_ack) vid_req = 1'b0;
            if (zor_ack) zor_req = 1'b0;
            t++;
            if (t > bound) begin
                fail("drain", $sformatf("transactions still open after %0d cycles, required none", t));
                cmd_q.delete(); vack_q.delete(); vdata_q.delete(); zack_q.delete();
                vid_req = 1'b0;
                zor_req = 1'b0;
                break;
            end
        end
        tick();
    endtask

    // Model SDRAM controller: cmd_ready after rdy_delay cycles of valid, read data data_delay later.
    initial begin
        int age = 0;
        int rd_wait = 0;
        logic last_valid = 1'b0;
        logic last_rd = 1'b0;
        logic [22:0] last_addr = '0;
        logic [15:0] rd_val = '0;
        logic acc;
        cmd_ready = 1'b0;
        data_out_ready = 1'b0;
        ram_rdata = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            acc = last_valid && cmd_ready;
            data_out_ready = 1'b0;
            ram_rdata = 16'hDEAD;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    data_out_ready = 1'b1;
                    ram_rdata = rd_val;
                end
            end
            if (acc && last_rd) begin
                rd_wait = data_delay;
                rd_val = rd_model(last_addr);
            end
            if (stray) begin
                data_out_ready = 1'b1;
                ram_rdata = 16'hBEEF;
            end
            last_valid = ram_cmd_valid && rst_n;
            last_rd = !ram_cmd_write && !ram_cmd_refresh;
            last_addr = ram_addr;
            if (!ram_cmd_valid) age = 0;
            cmd_ready = !block && (ram_cmd_valid ? (age >= rdy_delay) : (rdy_delay == 0));
            if (ram_cmd_valid) age++;
        end
    end

    // Monitor: compares every accepted command, ack and data pulse against the scoreboard.
    initial begin
        int ncyc = 0;
        int vlen = 0;
        int last_ref_cyc = -1;
        int last_cmd_cyc = 0;
        logic prev_valid = 1'b0, prev_acc = 1'b0, prev_write = 1'b0, prev_refresh = 1'b0;
        logic [22:0] prev_addr = '0;
        logic [15:0] prev_wdata = '0;
        logic [1:0] prev_mask = '0;
        cmd_t e;
        zack_t z;
        logic [15:0] vd;
        int dummy;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!chk_period) last_ref_cyc = -1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                prev_acc = 1'b0;
                vlen = 0;
            end else begin
                if (prev_acc) check("valid_drop_after_accept", ram_cmd_valid, 1'b0);
                if (ram_cmd_valid) begin
                    if (prev_valid && !prev_acc)
                        check("cmd_hold", {ram_cmd_write, ram_cmd_refresh, ram_addr, ram_wdata, ram_mask},
                              {prev_write, prev_refresh, prev_addr, prev_wdata, prev_mask});
                    vlen = (prev_valid && !prev_acc) ? vlen + 1 : 1;
                end
                if (ram_cmd_valid && cmd_ready) begin
                    if (ram_cmd_refresh) begin
                        check("refresh_fields", {ram_cmd_write, ram_addr, ram_mask}, '0);
                        if (chk_period && last_ref_cyc >= 0)
                            check("refresh_period", ncyc - last_ref_cyc, 16);
                        last_ref_cyc = ncyc;
                        ref_cnt++;
                    end else if (cmd_q.size() == 0) begin
                        fail("unexpected_cmd", $sformatf("addr %0h accepted, required no command", ram_addr));
                    end else begin
                        e = cmd_q.pop_front();
                        check("cmd_fields", {ram_cmd_write, ram_addr, ram_mask}, {e.write, e.addr, e.mask});
                        if (e.write) check("cmd_wdata", ram_wdata, e.wdata);
                        check("cmd_valid_cycles", vlen, e.len);
                        last_cmd_cyc = ncyc;
                    end
                end
                if (vid_ack) begin
                    if (vack_q.size() == 0) fail("unexpected_vid_ack", "vid_ack=1, required 0");
                    else begin
                        dummy = vack_q.pop_front();
                        check("vid_ack_latency", ncyc - last_cmd_cyc, 1);
                    end
                end
                if (vid_data_valid) begin
                    if (vdata_q.size() == 0) fail("unexpected_vid_data_valid", "vid_data_valid=1, required 0");
                    else begin
                        vd = vdata_q.pop_front();
                        check("vid_data", vid_data, vd);
                    end
                end
                if (zor_ack) begin
                    if (zack_q.size() == 0) fail("unexpected_zor_ack", "zor_ack=1, required 0");
                    else begin
                        z = zack_q.pop_front();
                        if (z.rd) check("zor_rdata", zor_rdata, z.data);
                        else check("zor_write_ack_latency", ncyc - last_cmd_cyc, 1);
                    end
                end
                prev_valid = ram_cmd_valid;
                prev_acc = ram_cmd_valid && cmd_ready;
                prev_write = ram_cmd_write;
                prev_refresh = ram_cmd_refresh;
                prev_addr = ram_addr;
                prev_wdata = ram_wdata;
                prev_mask = ram_mask;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at 300000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int zacks;
        int first_k;
        logic first_ref;
        bit done;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_valid", ram_cmd_valid, 1'b0);
        check("rst_acks", {vid_ack, vid_data_valid, zor_ack}, 3'b000);
        check("rst_data", {vid_data, zor_rdata}, 32'h0);
        check("rst_overrun", ref_overrun, 1'b0);
        rst_n = 1'b1;

        // Idle refresh cadence
        ref_cnt = 0;
        chk_period = 1'b1;
        repeat (70) tick();
        chk_period = 1'b0;
        check("refresh_count_70_cycles", ref_cnt, 4);

        // Zorro write, Zorro read, Zorro write at top address with upper byte only
        push_zor(1'b1, 23'h00004C, 16'hFF00, 2'b11);
        zor_write = 1'b1; zor_addr = 23'h00004C; zor_wdata = 16'hFF00; zor_mask = 2'b11; zor_req = 1'b1;
        drain(100);
        push_zor(1'b0, 23'h000123, 16'h0000, 2'b01);
        zor_write = 1'b0; zor_addr = 23'h000123; zor_mask = 2'b01; zor_req = 1'b1;
        drain(100);
        push_zor(1'b1, 23'h7FFFFF, 16'h1234, 2'b10);
        zor_write = 1'b1; zor_addr = 23'h7FFFFF; zor_wdata = 16'h1234; zor_mask = 2'b10; zor_req = 1'b1;
        drain(100);

        // Video read with a slow controller, then one at the top address
        rdy_delay = 3;
        push_vid(23'h010000, 4);
        vid_addr = 23'h010000; vid_req = 1'b1;
        drain(100);
        rdy_delay = 0;
        push_vid(23'h7FFFFF, 1);
        vid_addr = 23'h7FFFFF; vid_req = 1'b1;
        drain(100);

        // Stray data_out_ready while nothing is outstanding
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (3) tick();
        check("vid_data_hold", vid_data, 16'hB700);
        check("zor_rdata_hold", zor_rdata, 16'h49DC);

        // Both requesters held high: four video grants, then one Zorro, twice
        for (int g = 0; g < 2; g++) begin
            for (int v = 0; v < 4; v++) push_vid(23'h000100, 1);
            push_zor(1'b1, 23'h000200, 16'hA5A5, 2'b11);
        end
        vid_addr = 23'h000100; vid_req = 1'b1;
        zor_write = 1'b1; zor_addr = 23'h000200; zor_wdata = 16'hA5A5; zor_mask = 2'b11; zor_req = 1'b1;
        zacks = 0;
        done = 1'b0;
        for (int t = 0; t < 600 && !done; t++) begin
            tick();
            if (zor_ack) zacks++;
            if (zacks == 2) begin
                vid_req = 1'b0;
                zor_req = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) fail("fairness", $sformatf("%0d zorro acks in 600 cycles, required 2", zacks));
        vid_req = 1'b0;
        zor_req = 1'b0;
        drain(100);

        // Controller stalled long enough for refresh to be missed
        check("overrun_before_stall", ref_overrun, 1'b0);
        block = 1'b1;
        repeat (40) tick();
        check("overrun_after_stall", ref_overrun, 1'b1);
        block = 1'b0;
        repeat (30) tick();
        check("overrun_sticky", ref_overrun, 1'b1);

        // Reset while a video read waits for data
        data_delay = 12;
        cmd_q.push_back('{1'b0, 23'h000555, 16'h0000, 2'b11, 1});
        vack_q.push_back(1);
        vid_addr = 23'h000555; vid_req = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            tick();
            if (vid_ack) begin
                vid_req = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) fail("abort_setup", "no vid_ack within 100 cycles, required one");
        vid_req = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_cmd_outputs", {ram_cmd_valid, ram_cmd_write, ram_cmd_refresh, ram_addr, ram_wdata, ram_mask}, '0);
        check("abort_ack_outputs", {vid_ack, vid_data_valid, zor_ack}, 3'b000);
        check("abort_data_outputs", {vid_data, zor_rdata}, 32'h0);
        check("abort_overrun", ref_overrun, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        data_delay = 2;

        // Refresh timing after release, and refresh ahead of both requesters
        push_vid(23'h000010, 1);
        push_zor(1'b1, 23'h000020, 16'h5A5A, 2'b01);
        first_k = -1;
        first_ref = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 16) begin
                vid_addr = 23'h000010; vid_req = 1'b1;
                zor_write = 1'b1; zor_addr = 23'h000020; zor_wdata = 16'h5A5A; zor_mask = 2'b01;
                zor_req = 1'b1;
            end
            if (ram_cmd_valid && first_k < 0) begin
                first_k = k;
                first_ref = ram_cmd_refresh;
            end
            if (vid_ack) vid_req = 1'b0;
            if (zor_ack) zor_req = 1'b0;
        end
        check("first_cmd_after_reset_cycle", first_k, 17);
        check("first_cmd_after_reset_is_refresh", first_ref, 1'b1);
        drain(100);
        check("overrun_after_reset", ref_overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
